// File: rtl/led_spinner_game_ctrl_if.sv
// Link between the round sequencer and the led_spinner wheel, plus the player-facing result
// indicators.
//   seg_bits_in    : wheel segment readback (bits [5:0] = outer ring)
//   speed_bits_out : one-hot speed code to the wheel (4'b1000 fastest)
//   stop_wheel_out : 1 = wheel frozen
//   guess_bits_out : guess segments shown on the wheel
//   win_out/lose_out, score_out, state_out : result, saturating score, debug state
interface led_spinner_game_ctrl_if;
  logic [6:0] seg_bits_in;
  logic [3:0] speed_bits_out;
  logic       stop_wheel_out;
  logic [5:0] guess_bits_out;
  logic       win_out;
  logic       lose_out;
  logic [3:0] score_out;
  logic [2:0] state_out;

  // Controller side
  modport master (
    input  seg_bits_in,
    output speed_bits_out, stop_wheel_out, guess_bits_out,
    output win_out, lose_out, score_out, state_out
  );

  // Wheel / observer side
  modport slave (
    output seg_bits_in,
    input  speed_bits_out, stop_wheel_out, guess_bits_out,
    input  win_out, lose_out, score_out, state_out
  );
endinterface

// File: rtl/led_spinner_game_ctrl.sv
// Round sequencer for the led_spinner wheel: conditions the start/stop buttons and guess
// switches, runs the spin -> brake ramp -> halt sequence, reads the stopped segment back and
// keeps a saturating win count.
//   clk, rst_n   : clock and asynchronous active-low reset
//   start_btn_in : raw start button (asynchronous, active-high)
//   stop_btn_in  : raw stop button (asynchronous, active-high)
//   guess_sw_in  : raw guess switches, bit i = outer segment i
//   spin_if      : wheel link and result outputs (master side)
module led_spinner_game_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 500_000,
  parameter int unsigned STEP_CYCLES     = 25_000_000,
  parameter int unsigned RESULT_CYCLES   = 100_000_000
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           start_btn_in,
  input  logic                           stop_btn_in,
  input  logic [5:0]                     guess_sw_in,
  led_spinner_game_ctrl_if.master        spin_if
);

  localparam int unsigned NumIn  = 8;
  localparam int unsigned DbW    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int unsigned MaxCyc = (RESULT_CYCLES > STEP_CYCLES) ? RESULT_CYCLES : STEP_CYCLES;
  // Must also hold the value 1 used by the two-cycle HALT wait.
  localparam int unsigned CntW   = (MaxCyc > 2) ? $clog2(MaxCyc) : 2;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StSpin   = 3'd1,
    StBrake  = 3'd2,
    StHalt   = 3'd3,
    StResult = 3'd4
  } state_e;

  // ---------------- Input conditioning ----------------
  // Bit 0 = start, bit 1 = stop, bits [7:2] = guess switches.
  logic [NumIn-1:0]           raw;
  logic [NumIn-1:0]           sync1_q, sync2_q;
  logic [NumIn-1:0]           db_q, db_d;
  logic [NumIn-1:0][DbW-1:0]  db_cnt_q, db_cnt_d;
  logic [1:0]                 btn_prev_q;
  logic                       start_pulse, stop_pulse;
  logic [5:0]                 sw_db;

  assign raw = {guess_sw_in, stop_btn_in, start_btn_in};

  // Counter tracks consecutive samples disagreeing with the accepted level; any agreeing
  // sample restarts it.
  always_comb begin
    db_d     = db_q;
    db_cnt_d = db_cnt_q;
    for (int i = 0; i < NumIn; i++) begin
      if (sync2_q[i] != db_q[i]) begin
        if (db_cnt_q[i] == DbW'(DEBOUNCE_CYCLES - 1)) begin
          db_d[i]     = sync2_q[i];
          db_cnt_d[i] = '0;
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + DbW'(1);
        end
      end else begin
        db_cnt_d[i] = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      db_q       <= '0;
      db_cnt_q   <= '0;
      btn_prev_q <= '0;
    end else begin
      sync1_q    <= raw;
      sync2_q    <= sync1_q;
      db_q       <= db_d;
      db_cnt_q   <= db_cnt_d;
      btn_prev_q <= db_q[1:0];
    end
  end

  assign start_pulse = db_q[0] & ~btn_prev_q[0];
  assign stop_pulse  = db_q[1] & ~btn_prev_q[1];
  assign sw_db       = db_q[7:2];

  // ---------------- Round FSM ----------------
  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [1:0]      step_q, step_d;
  logic [5:0]      guess_q, guess_d;
  logic            hit_q, hit_d;
  logic [3:0]      score_q, score_d;
  logic [5:0]      seg;
  logic            seg_valid, seg_hit;
  logic            unused_seg_center;

  assign seg               = spin_if.seg_bits_in[5:0];
  assign unused_seg_center = spin_if.seg_bits_in[6];
  // Exactly one outer segment lit.
  assign seg_valid = (seg != 6'd0) && ((seg & (seg - 6'd1)) == 6'd0);
  assign seg_hit   = seg_valid && |(seg & guess_q);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    step_d  = step_q;
    guess_d = guess_q;
    hit_d   = hit_q;
    score_d = score_q;
    unique case (state_q)
      StIdle: begin
        if (start_pulse && (sw_db != 6'd0)) begin
          guess_d = sw_db;
          state_d = StSpin;
        end
      end
      StSpin: begin
        if (stop_pulse) begin
          state_d = StBrake;
          step_d  = 2'd0;
          cnt_d   = '0;
        end
      end
      StBrake: begin
        if (cnt_q == CntW'(STEP_CYCLES - 1)) begin
          cnt_d = '0;
          if (step_q == 2'd3) begin
            state_d = StHalt;
          end else begin
            step_d = step_q + 2'd1;
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StHalt: begin
        // Second HALT cycle: wheel has settled, take the reading.
        if (cnt_q == CntW'(1)) begin
          cnt_d   = '0;
          hit_d   = seg_hit;
          state_d = StResult;
          if (seg_hit && (score_q != 4'hF)) begin
            score_d = score_q + 4'd1;
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StResult: begin
        if (cnt_q == CntW'(RESULT_CYCLES - 1)) begin
          cnt_d   = '0;
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      step_q  <= 2'd0;
      guess_q <= 6'd0;
      hit_q   <= 1'b0;
      score_q <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      step_q  <= step_d;
      guess_q <= guess_d;
      hit_q   <= hit_d;
      score_q <= score_d;
    end
  end

  // ---------------- Outputs ----------------
  assign spin_if.speed_bits_out = (state_q == StBrake) ? (4'b1000 >> step_q) : 4'b1000;
  assign spin_if.stop_wheel_out = !((state_q == StSpin) || (state_q == StBrake));
  assign spin_if.guess_bits_out = (state_q == StIdle) ? sw_db : guess_q;
  assign spin_if.win_out        = (state_q == StResult) && hit_q;
  assign spin_if.lose_out       = (state_q == StResult) && !hit_q;
  assign spin_if.score_out      = score_q;
  assign spin_if.state_out      = state_q;

endmodule
